// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks one active-low column at a time and
// reports the single pressed key as a raw code plus a held level.
module keypad_scanner #(
   parameter int SCAN_DIV    = 4800,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_pressed
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   localparam logic [0:0] ST_SCAN = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [3:0]    sync_q [SYNC_STAGES];
   logic [3:0]    rows_s;
   logic [3:0]    rows_n;

   logic [0:0]    state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    row_q, row_d;
   logic [3:0]    code_q, code_d;
   logic          press_q, press_d;
   logic [3:0]    cols_q, cols_d;

   logic [1:0]    row_enc;
   logic          one_low;

   function automatic logic [3:0] key_map(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] k;
      unique case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hA;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hB;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hC;
         4'b11_00: k = 4'hE;
         4'b11_01: k = 4'h0;
         4'b11_10: k = 4'hF;
         default:  k = 4'hD;
      endcase
      return k;
   endfunction

   assign rows_s = sync_q[SYNC_STAGES-1];
   assign rows_n = ~rows_s;

   // Zero or several low rows (ghosting) are treated alike: no key.
   always_comb begin
      row_enc = 2'd0;
      one_low = 1'b0;
      unique case (rows_n)
         4'b0001: begin row_enc = 2'd0; one_low = 1'b1; end
         4'b0010: begin row_enc = 2'd1; one_low = 1'b1; end
         4'b0100: begin row_enc = 2'd2; one_low = 1'b1; end
         4'b1000: begin row_enc = 2'd3; one_low = 1'b1; end
         default: begin row_enc = 2'd0; one_low = 1'b0; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      code_d  = code_q;
      press_d = press_q;
      unique case (state_q)
         ST_SCAN: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (one_low) begin
                  state_d = ST_HOLD;
                  row_d   = row_enc;
                  code_d  = key_map(row_enc, col_q);
                  press_d = 1'b1;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d = '0;
            if (rows_s[row_q]) begin
               state_d = ST_SCAN;
               press_d = 1'b0;
               col_d   = col_q + 2'd1;
            end
         end
      endcase
      cols_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1111;
         state_q <= ST_SCAN;
         col_q   <= 2'd0;
         cnt_q   <= '0;
         row_q   <= 2'd0;
         code_q  <= 4'h0;
         press_q <= 1'b0;
         cols_q  <= 4'b1110;
      end else begin
         sync_q[0] <= rows;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         state_q <= state_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         code_q  <= code_d;
         press_q <= press_d;
         cols_q  <= cols_d;
      end
   end

   assign cols        = cols_q;
   assign key_code    = code_q;
   assign key_pressed = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model
// (SCAN_DIV=8, SYNC_STAGES=2).
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key_code;
   logic       key_pressed;

   logic [3:0][3:0] keys = '0;
   logic [3:0]      glitch = '0;
   logic            cols_bad = 1'b0;
   logic            seen_kp;
   logic            seen_move;

   int nvec = 0;
   int nerr = 0;

   logic [3:0] exp_map [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   keypad_scanner #(
      .SCAN_DIV   (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rows       (rows),
      .cols       (cols),
      .key_code   (key_code),
      .key_pressed(key_pressed)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int r = 0; r < 4; r++)
         rows[r] = !(|(keys[r] & ~cols)) || glitch[r];
   end

   always @(negedge clk) begin
      if (!reset && $countones(~cols) != 1) cols_bad = 1'b1;
   end

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_kp(input logic val, input int budget,
                          input string tag);
      int n = 0;
      while (key_pressed !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {3'b0, key_pressed}, {3'b0, val});
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      chk("rst_cols", cols, 4'b1110);
      chk("rst_code", key_code, 4'h0);
      chk("rst_kp", {3'b0, key_pressed}, 4'h0);
      tick(7);
      chk("rot_c0_end", cols, 4'b1110);
      tick(1);
      chk("rot_c1", cols, 4'b1101);
      tick(8);
      chk("rot_c2", cols, 4'b1011);
      tick(8);
      chk("rot_c3", cols, 4'b0111);
      tick(8);
      chk("rot_wrap", cols, 4'b1110);

      // single press of '5'
      keys[1][1] = 1'b1;
      wait_kp(1'b1, 35, "p5_kp");
      chk("p5_code", key_code, 4'h5);
      chk("p5_cols", cols, 4'b1101);
      tick(4);
      chk("p5_frozen", cols, 4'b1101);
      keys[1][1] = 1'b0;
      tick(2);
      chk("p5_rel2", {3'b0, key_pressed}, 4'h1);
      tick(1);
      chk("p5_rel3", {3'b0, key_pressed}, 4'h0);
      chk("p5_nextcol", cols, 4'b1011);
      chk("p5_codeheld", key_code, 4'h5);

      // full map
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            keys[r][c] = 1'b1;
            wait_kp(1'b1, 40, "map_kp");
            chk($sformatf("map_r%0dc%0d", r, c), key_code, exp_map[r*4+c]);
            keys[r][c] = 1'b0;
            wait_kp(1'b0, 6, "map_rel");
         end
      end

      // ghosting: '1' and '4' share column 0
      keys[0][0] = 1'b1;
      keys[1][0] = 1'b1;
      seen_kp = 1'b0;
      seen_move = 1'b0;
      for (int i = 0; i < 48; i++) begin
         tick(1);
         if (key_pressed) seen_kp = 1'b1;
         if (cols != 4'b1110) seen_move = 1'b1;
      end
      chk("ghost_kp", {3'b0, seen_kp}, 4'h0);
      chk("ghost_scan", {3'b0, seen_move}, 4'h1);
      keys = '0;
      tick(4);

      // second key during HOLD is ignored
      keys[0][0] = 1'b1;
      wait_kp(1'b1, 40, "hold1_kp");
      chk("hold1_code", key_code, 4'h1);
      keys[0][1] = 1'b1;
      tick(20);
      chk("hold1_add2", key_code, 4'h1);
      chk("hold1_kp2", {3'b0, key_pressed}, 4'h1);
      keys = '0;
      wait_kp(1'b0, 6, "hold1_rel");

      // reset in the middle of HOLD
      keys[2][2] = 1'b1;
      wait_kp(1'b1, 40, "p9_kp");
      chk("p9_code", key_code, 4'h9);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("mrst_kp", {3'b0, key_pressed}, 4'h0);
      chk("mrst_cols", cols, 4'b1110);
      chk("mrst_code", key_code, 4'h0);
      wait_kp(1'b1, 40, "p9_redet");
      chk("p9_recode", key_code, 4'h9);
      keys = '0;
      wait_kp(1'b0, 6, "p9_rel");

      // one-cycle bounce on '0' during HOLD
      keys[3][1] = 1'b1;
      wait_kp(1'b1, 40, "p0_kp");
      chk("p0_code", key_code, 4'h0);
      glitch[3] = 1'b1;
      tick(1);
      glitch[3] = 1'b0;
      wait_kp(1'b0, 5, "bnc_drop");
      chk("bnc_code", key_code, 4'h0);
      wait_kp(1'b1, 40, "bnc_redet");
      chk("bnc_recode", key_code, 4'h0);
      keys = '0;
      wait_kp(1'b0, 6, "p0_rel");

      chk("cols_onehot", {3'b0, cols_bad}, 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
